// File: rtl/ttl_dec_pkg.sv
// Shared constants for the TTL-like decoder.
// Holds the legal one-hot sel codes and the bit positions of each destination
// within the 8-bit one-hot destination vector and the wr_strobe output.
package ttl_dec_pkg;

  localparam logic [3:0] SEL_Z = 4'b0001;
  localparam logic [3:0] SEL_D = 4'b0010;
  localparam logic [3:0] SEL_A = 4'b0100;

  localparam int unsigned NUM_DEST = 8;

  // Bit order {b4,b3,b2,b1,a2,a1,d,z}
  localparam int unsigned WR_Z  = 0;
  localparam int unsigned WR_D  = 1;
  localparam int unsigned WR_A1 = 2;
  localparam int unsigned WR_A2 = 3;
  localparam int unsigned WR_B1 = 4;
  localparam int unsigned WR_B2 = 5;
  localparam int unsigned WR_B3 = 6;
  localparam int unsigned WR_B4 = 7;

endpackage

// File: rtl/ttl_dec_route.sv
// Combinational destination decoder.
// Ports:
//   sel     - 4-bit one-hot destination select (z, d, a-group, anything else b-group)
//   sel2    - a-group sub-select (0 a1, 1 a2)
//   sel3    - b-group sub-select (00 b1 .. 11 b4)
//   dest    - 8-bit one-hot destination, bit order {b4,b3,b2,b1,a2,a1,d,z}
//   illegal - sel was not one of the three legal one-hot codes
module ttl_dec_route
  import ttl_dec_pkg::*;
(
  input  logic [3:0]          sel,
  input  logic                sel2,
  input  logic [1:0]          sel3,
  output logic [NUM_DEST-1:0] dest,
  output logic                illegal
);

  always_comb begin
    dest    = '0;
    illegal = 1'b0;
    // sel is not guaranteed one-hot, so a plain case with a catch-all default
    case (sel)
      SEL_Z: dest[WR_Z] = 1'b1;
      SEL_D: dest[WR_D] = 1'b1;
      SEL_A: begin
        if (sel2) dest[WR_A2] = 1'b1;
        else      dest[WR_A1] = 1'b1;
      end
      default: begin
        // Zero and multi-hot codes fall through to the b-group
        illegal = 1'b1;
        case (sel3)
          2'b00:   dest[WR_B1] = 1'b1;
          2'b01:   dest[WR_B2] = 1'b1;
          2'b10:   dest[WR_B3] = 1'b1;
          default: dest[WR_B4] = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ttl_like_decoder.sv
// Two-stage data router: accepts a word plus destination select, then writes it
// into one of eight destination registers on the following edge.
// Optional feature: define DEC_ERR_COUNT_EN to add err_cnt, a saturating count
// of writes made with an illegal sel.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   g, sel, sel2, sel3    - data word and destination select
//   in_valid, in_ready    - input handshake (in_ready = ~freeze)
//   freeze                - stalls stage, destinations and sel_err; masks wr_strobe
//   clr_d                 - synchronous clear of d, effective even when frozen
//   z, d, a1, a2, b1..b4  - destination registers
//   wr_strobe             - one-cycle one-hot write pulse {b4,b3,b2,b1,a2,a1,d,z}
//   err_cnt               - (DEC_ERR_COUNT_EN only) saturating illegal-write count
//   sel_err               - last write used an illegal sel
module ttl_like_decoder
  import ttl_dec_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] g,
  input  logic [3:0]       sel,
  input  logic             sel2,
  input  logic [1:0]       sel3,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             freeze,
  input  logic             clr_d,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] b2,
  output logic [WIDTH-1:0] b3,
  output logic [WIDTH-1:0] b4,
  output logic [7:0]       wr_strobe,
`ifdef DEC_ERR_COUNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic             sel_err
);

  logic [NUM_DEST-1:0] route_dest;
  logic                route_illegal;

  ttl_dec_route u_route (
    .sel     (sel),
    .sel2    (sel2),
    .sel3    (sel3),
    .dest    (route_dest),
    .illegal (route_illegal)
  );

  logic                           accept;
  logic                           do_write;
  logic [WIDTH-1:0]               stage_data_q;
  logic [NUM_DEST-1:0]            stage_dest_q;
  logic                           stage_err_q;
  logic                           stage_valid_q;
  logic [NUM_DEST-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NUM_DEST-1:0]            strobe_q, strobe_d;
  logic                           sel_err_q, sel_err_d;

  assign in_ready = ~freeze;
  assign accept   = in_valid & in_ready;
  assign do_write = stage_valid_q & ~freeze;

  // Stage register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      stage_dest_q  <= '0;
      stage_err_q   <= 1'b0;
    end else if (!freeze) begin
      stage_valid_q <= accept;
      if (accept) begin
        stage_data_q <= g;
        stage_dest_q <= route_dest;
        stage_err_q  <= route_illegal;
      end
    end
  end

  always_comb begin
    regs_d    = regs_q;
    strobe_d  = '0;
    sel_err_d = sel_err_q;
    if (do_write) begin
      for (int unsigned i = 0; i < NUM_DEST; i++) begin
        if (stage_dest_q[i]) regs_d[i] = stage_data_q;
      end
      strobe_d  = stage_dest_q;
      sel_err_d = stage_err_q;
    end
    // Clear beats a simultaneous d write; the strobe still fires
    if (clr_d) regs_d[WR_D] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q    <= '0;
      strobe_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      strobe_q  <= strobe_d;
      sel_err_q <= sel_err_d;
    end
  end

`ifdef DEC_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (do_write && stage_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  // Masked combinationally so the strobe reads zero for the whole frozen cycle
  assign wr_strobe = strobe_q & {NUM_DEST{~freeze}};
  assign sel_err   = sel_err_q;

  assign z  = regs_q[WR_Z];
  assign d  = regs_q[WR_D];
  assign a1 = regs_q[WR_A1];
  assign a2 = regs_q[WR_A2];
  assign b1 = regs_q[WR_B1];
  assign b2 = regs_q[WR_B2];
  assign b3 = regs_q[WR_B3];
  assign b4 = regs_q[WR_B4];

endmodule

// File: tb/tb_ttl_like_decoder.sv
// Scoreboard bench for ttl_like_decoder (WIDTH=4). Works with or without
// DEC_ERR_COUNT_EN defined.
module tb_ttl_like_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] g;
  logic [3:0] sel;
  logic       sel2;
  logic [1:0] sel3;
  logic       in_valid;
  logic       in_ready;
  logic       freeze;
  logic       clr_d;
  logic [3:0] z, d, a1, a2, b1, b2, b3, b4;
  logic [7:0] wr_strobe;
  logic       sel_err;
`ifdef DEC_ERR_COUNT_EN
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  ttl_like_decoder #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .g         (g),
    .sel       (sel),
    .sel2      (sel2),
    .sel3      (sel3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .freeze    (freeze),
    .clr_d     (clr_d),
    .z         (z),
    .d         (d),
    .a1        (a1),
    .a2        (a2),
    .b1        (b1),
    .b2        (b2),
    .b3        (b3),
    .b4        (b4),
    .wr_strobe (wr_strobe),
`ifdef DEC_ERR_COUNT_EN
    .err_cnt   (err_cnt),
`endif
    .sel_err   (sel_err)
  );

  typedef struct {
    logic [7:0] strobe;
    int         idx;
    logic [3:0] val;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] exp_regs [8];
  logic [7:0] exp_cnt;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_regs();
    return {b4, b3, b2, b1, a2, a1, d, z};
  endfunction

  function automatic logic [31:0] model_regs();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[i*4 +: 4] = exp_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) exp_regs[i] = 4'h0;
    exp_cnt = 8'd0;
  endtask

  // Present one word for one accepting edge; optionally predict its write
  task automatic send(input logic [3:0] gv, input logic [3:0] s, input logic s2,
                      input logic [1:0] s3, input int idx, input logic [3:0] ev,
                      input logic ee, input logic push_it);
    exp_t e;
    g = gv; sel = s; sel2 = s2; sel3 = s3; in_valid = 1'b1;
    if (push_it) begin
      if (ee && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      e.strobe = 8'd1 << idx;
      e.idx    = idx;
      e.val    = ev;
      e.err    = ee;
      e.cnt    = exp_cnt;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_queue_empty", sb.size(), 0);
    chk("strobe_idle", {24'd0, wr_strobe}, 0);
  endtask

  // Monitor: every nonzero strobe must match the oldest predicted write
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && wr_strobe != 8'd0) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {24'd0, wr_strobe}, 0);
        end else begin
          e = sb.pop_front();
          exp_regs[e.idx] = e.val;
          chk("wr_strobe", {24'd0, wr_strobe}, {24'd0, e.strobe});
          chk("dest_regs", dut_regs(), model_regs());
          chk("sel_err", {31'd0, sel_err}, {31'd0, e.err});
`ifdef DEC_ERR_COUNT_EN
          chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.cnt});
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; g = '0; sel = '0; sel2 = 1'b0; sel3 = '0;
    in_valid = 1'b0; freeze = 1'b0; clr_d = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_regs", dut_regs(), 0);
    chk("reset_strobe", {24'd0, wr_strobe}, 0);
    chk("reset_sel_err", {31'd0, sel_err}, 0);
    chk("in_ready_idle", {31'd0, in_ready}, 1);
`ifdef DEC_ERR_COUNT_EN
    chk("reset_err_cnt", {24'd0, err_cnt}, 0);
`endif

    // Legal z write, then default routing cases and a legal write clearing sel_err
    send(4'hA, 4'b0001, 1'b0, 2'b00, 0, 4'hA, 1'b0, 1'b1);
    drain();
    send(4'h5, 4'b1000, 1'b0, 2'b10, 6, 4'h5, 1'b1, 1'b1);
    drain();
    send(4'h1, 4'b0001, 1'b0, 2'b00, 0, 4'h1, 1'b0, 1'b1);
    send(4'hC, 4'b0011, 1'b1, 2'b00, 4, 4'hC, 1'b1, 1'b1);
    send(4'h2, 4'b0000, 1'b0, 2'b11, 7, 4'h2, 1'b1, 1'b1);
    send(4'hE, 4'b1111, 1'b0, 2'b01, 5, 4'hE, 1'b1, 1'b1);
    drain();

    // Back-to-back a-group
    send(4'h3, 4'b0100, 1'b0, 2'b00, 2, 4'h3, 1'b0, 1'b1);
    send(4'h7, 4'b0100, 1'b1, 2'b00, 3, 4'h7, 1'b0, 1'b1);
    drain();

    // Freeze holds the staged d write for 3 cycles
    send(4'hF, 4'b0010, 1'b0, 2'b00, 1, 4'hF, 1'b0, 1'b1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("freeze_d_hold", {28'd0, d}, 0);
      chk("freeze_in_ready", {31'd0, in_ready}, 0);
      chk("freeze_no_strobe", {24'd0, wr_strobe}, 0);
    end
    freeze = 1'b0;
    drain();

    // clr_d on the write edge wins over the data
    send(4'hF, 4'b0010, 1'b0, 2'b00, 1, 4'h0, 1'b0, 1'b1);
    clr_d = 1'b1;
    @(posedge clk);
    #1 clr_d = 1'b0;
    drain();

    // clr_d acts while frozen
    send(4'h6, 4'b0010, 1'b0, 2'b00, 1, 4'h6, 1'b0, 1'b1);
    drain();
    freeze = 1'b1; clr_d = 1'b1;
    @(posedge clk);
    #1 clr_d = 1'b0; freeze = 1'b0;
    exp_regs[1] = 4'h0;
    chk("clr_while_frozen", dut_regs(), model_regs());

    // Reset mid-operation discards the staged word
    send(4'h9, 4'b0100, 1'b0, 2'b00, 2, 4'h9, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    chk("midreset_regs", dut_regs(), 0);
    chk("midreset_strobe", {24'd0, wr_strobe}, 0);
    chk("midreset_sel_err", {31'd0, sel_err}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_reset_a1", {28'd0, a1}, 0);
    chk("post_reset_regs", dut_regs(), 0);

`ifdef DEC_ERR_COUNT_EN
    // Saturation
    for (int i = 0; i < 260; i++) begin
      send(i[3:0], 4'b0000, 1'b0, i[1:0], 4 + (i % 4), i[3:0], 1'b1, 1'b1);
    end
    drain();
    chk("err_cnt_saturated", {24'd0, err_cnt}, 255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ttl_like_decoder.md
TTL_LIKE_DECODER -- requirements
Module: ttl_like_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the data path and of every destination register.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port g, input, WIDTH bits: data word to be routed.
REQ-005 SHALL have port sel, input, 4 bits: one-hot destination select (0001 z, 0010 d, 0100 a-group, other b-group).
REQ-006 SHALL have port sel2, input, 1 bit: a-group sub-select (0 a1, 1 a2).
REQ-007 SHALL have port sel3, input, 2 bits: b-group sub-select (00 b1, 01 b2, 10 b3, 11 b4).
REQ-008 SHALL have port in_valid, input, 1 bit: g/sel/sel2/sel3 are valid this cycle.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-010 SHALL have port freeze, input, 1 bit: stalls the pipeline.
REQ-011 SHALL have port clr_d, input, 1 bit: synchronous clear of register d.
REQ-012 SHALL have ports z, d, a1, a2, b1, b2, b3, b4, outputs, WIDTH bits each: the destination registers.
REQ-013 SHALL have port wr_strobe, output, 8 bits: one-hot write pulse, bit order {b4,b3,b2,b1,a2,a1,d,z}.
REQ-014 SHALL have port sel_err, output, 1 bit: the last performed write used a sel that is not one of 0001/0010/0100.

Function
REQ-015 SHALL set in_ready = ~freeze, combinationally.
REQ-016 SHALL accept a word when in_valid & in_ready at a clock edge, capturing g, the decoded destination and the illegal-sel flag into a stage register, and setting stage_valid.
REQ-017 SHALL, on the edge after acceptance with freeze low, write the staged data to exactly one destination register, pulse the matching wr_strobe bit for one cycle, and clear stage_valid unless a new word is accepted on the same edge. Latency: acceptance edge plus one edge.
REQ-018 SHALL sustain one word per cycle with back-to-back in_valid and freeze low.
REQ-019 SHALL route any sel other than 0001, 0010 or 0100, including 0000 and multi-hot values, to the b-group selected by sel3, and SHALL set sel_err=1 on that write.
REQ-020 SHALL set sel_err=0 on any legal write; sel_err holds between writes.
REQ-021 SHALL, while freeze is high, hold the stage register, all destination registers and sel_err, and drive wr_strobe to 0.
REQ-022 SHALL, when clr_d is high and a d write occurs on the same edge, clear d (clr wins) and still pulse wr_strobe[1]. clr_d SHALL act even while freeze is high.
REQ-023 SHALL hold every destination not being written.

Reset
REQ-024 SHALL, on reset assertion, immediately clear all destination registers, stage_valid, wr_strobe and sel_err to 0. A word in flight is discarded.
REQ-025 SHALL accept no word while reset is high. in_ready follows REQ-015.

Configuration
REQ-026 SHALL, with DEC_ERR_COUNT_EN defined, provide output err_cnt[7:0]: reset to 0, incremented on each write with sel_err, saturating at 255.
REQ-027 SHALL, without DEC_ERR_COUNT_EN, have no err_cnt port and no counter logic. All other behaviour is identical.

Structure
REQ-028 SHALL take constants SEL_Z=4'b0001, SEL_D=4'b0010, SEL_A=4'b0100 and the wr_strobe bit indices from package ttl_dec_pkg.
REQ-029 SHALL implement the decode of sel/sel2/sel3 into an 8-bit one-hot destination plus illegal flag in sub-module ttl_dec_route (combinational).

Verification
REQ-030 Legal write: reset, then accept g=4'hA, sel=0001 -> one edge later z=A, wr_strobe=00000001 for one cycle.
REQ-031 Default routing: accept g=5, sel=1000, sel3=10 -> b3=5, wr_strobe=01000000, sel_err=1. With DEC_ERR_COUNT_EN, err_cnt=1.
REQ-032 Back-to-back: accept a-group words 3 (sel2=0) then 7 (sel2=1) on consecutive edges -> a1=3, then a2=7 on consecutive cycles, with one strobe each.
REQ-033 Freeze and clear: accept g=F, sel=0010; freeze for 3 cycles -> d unchanged, in_ready=0, no strobe; release freeze -> d=F. Repeat with clr_d high on the write edge -> d=0.
REQ-034 Reset mid-operation: accept g=9, sel=0100, then assert reset before the next edge -> a1=0, no strobe after reset release.
REQ-035 Saturation (DEC_ERR_COUNT_EN): 260 illegal writes -> err_cnt=255.
